timer_dev: RTL and testbench



---
 rtl/timer_dev.sv | 119 +++++++++++
 tb/tb_timer_dev.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// counting FSM, and a maskable interrupt toward the CPU.
module timer_dev #(
  parameter int IM_BIT = 3,
  parameter int CTRL_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Sel,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  state_t            state_q, state_d;

  logic enable;
  logic auto_reload;
  logic store;

  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign store       = Sel & WE;

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    state_d    = state_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (count_q <= 32'd1) begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU stores are applied last so they override any same-edge FSM update.
    if (store) begin
      if (Addr == ADDR_CTRL) begin
        ctrl_d     = Din[CTRL_W-1:0];
        irq_flag_d = 1'b0;
      end else if (Addr == ADDR_PRESET) begin
        preset_d   = Din;
        irq_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: Dout = preset_q;
      ADDR_COUNT:  Dout = count_q;
      default:     Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl_q[IM_BIT] & irq_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized and scripted bench for timer_dev: a reference model predicts the
// load data and IRQ each cycle, and a monitor compares them at the falling edge.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic        Sel;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  always #5 clk = ~clk;

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .Sel  (Sel),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  typedef struct {
    logic [31:0] dout;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  // Reference model state: timer phase as a small integer code.
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  int          m_ph;

  function automatic void model_step(input logic rst, input logic s, input logic w,
                                     input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  c;
    logic [31:0] p;
    logic [31:0] n;
    bit          f;
    int          ph;
    if (rst) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 0; m_ph = PH_IDLE;
      return;
    end
    c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_ph;
    if (m_ph == PH_IDLE) begin
      if (m_ctrl[0]) ph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      n = m_preset; ph = PH_CNT;
    end else if (m_ph == PH_CNT) begin
      if (!m_ctrl[0]) ph = PH_IDLE;
      else if (m_count <= 1) begin n = 0; f = 1; ph = PH_INT; end
      else n = m_count - 1;
    end else begin
      if (m_ctrl[2:1] == 2'd1) begin f = 0; ph = PH_LOAD; end
      else begin c[0] = 1'b0; ph = PH_IDLE; end
    end
    if (s && w && a == 2'd0) begin c = d[3:0]; f = 0; end
    if (s && w && a == 2'd1) begin p = d; f = 0; end
    m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_ph = ph;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: the model absorbs the edge using the inputs that were
  // driven into it, then the next inputs are applied and the prediction queued.
  task automatic cyc(input logic rst, input logic s, input logic w,
                     input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    model_step(reset, Sel, WE, Addr, Din);
    ncyc++;
    #1;
    reset = rst; Sel = s; WE = w; Addr = a; Din = d;
    e.dout = model_read(a);
    e.irq  = m_ctrl[3] & m_flag;
    e.cyc  = ncyc;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, a, $urandom);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks += 2;
        if (Dout !== mon_e.dout) begin
          errors++;
          $display("FAIL dout cyc=%0d addr=%0d got=%h exp=%h", mon_e.cyc, Addr, Dout, mon_e.dout);
        end
        if (IRQ !== mon_e.irq) begin
          errors++;
          $display("FAIL irq cyc=%0d got=%b exp=%b", mon_e.cyc, IRQ, mon_e.irq);
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0] a;
    reset = 1'b1; Sel = 1'b0; WE = 1'b0; Addr = 2'd0; Din = 32'd0;
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    // Reset values and CTRL width masking.
    rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 1);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 2);
    wr(2'd0, 32'd0);
    rd(2'd3, 3);
    // One-shot with mask enabled; IRQ held until a CTRL store.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd(2'd2, 9);
    rd(2'd0, 3);
    wr(2'd0, 32'h8);
    rd(2'd0, 2);
    // Auto-reload pulses.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd(2'd2, 16);
    wr(2'd0, 32'd0);
    rd(2'd0, 3);
    // Masked completion, then enabling the mask after the flag was cleared.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h3);
    rd(2'd2, 8);
    wr(2'd0, 32'hB);
    rd(2'd0, 2);
    wr(2'd0, 32'd0);
    rd(2'd2, 3);
    // PRESET = 0 behaves as a count of one.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rd(2'd2, 6);
    // Mid-count PRESET change, freeze, and reload.
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);
    rd(2'd2, 12);
    wr(2'd1, 32'd100);
    rd(2'd2, 3);
    wr(2'd0, 32'd0);
    rd(2'd2, 3);
    wr(2'd0, 32'h1);
    rd(2'd2, 4);
    // Reset in the middle of a count.
    wr(2'd1, 32'd30);
    wr(2'd0, 32'h9);
    rd(2'd2, 10);
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 32'd0);
    rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 1);
    // Unselected stores are ignored.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 2'(i), $urandom);
    rd(2'd0, 1); rd(2'd1, 1);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      if (r < 2)       cyc(1'b1, 1'b1, 1'b0, a, $urandom);
      else if (r < 10) cyc(1'b0, 1'b0, 1'b1, a, $urandom);
      else if (r < 22) wr(a, (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom);
      else             cyc(1'b0, 1'b1, 1'b0, a, $urandom);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
